// File: rtl/lotr_ring_fabric.sv
// Unidirectional packet ring: one pipeline slot per stop, local inject FIFO,
// local eject port; packets for a busy stop bounce around instead of stalling.
module lotr_ring_fabric #(
  parameter int NUM_STOP  = 3,
  parameter int INJ_DEPTH = 4,
  parameter int OPCODE_W  = 2
) (
  input  logic                         QClk,
  input  logic                         RstQnnnH,
  input  logic [NUM_STOP-1:0]          InjValid,
  output logic [NUM_STOP-1:0]          InjReady,
  input  logic [NUM_STOP*10-1:0]       InjRequestor,
  input  logic [NUM_STOP*OPCODE_W-1:0] InjOpcode,
  input  logic [NUM_STOP*32-1:0]       InjAddress,
  input  logic [NUM_STOP*32-1:0]       InjData,
  output logic [NUM_STOP-1:0]          InjErr,
  output logic [NUM_STOP-1:0]          EjValid,
  input  logic [NUM_STOP-1:0]          EjReady,
  output logic [NUM_STOP*10-1:0]       EjRequestor,
  output logic [NUM_STOP*OPCODE_W-1:0] EjOpcode,
  output logic [NUM_STOP*32-1:0]       EjAddress,
  output logic [NUM_STOP*32-1:0]       EjData,
  output logic [NUM_STOP*16-1:0]       BounceCnt
);

  localparam int PW = $clog2(INJ_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [9:0]          req;
    logic [OPCODE_W-1:0] op;
    logic [31:0]         addr;
    logic [31:0]         data;
  } pkt_t;

  logic [NUM_STOP-1:0] ring_vld;
  pkt_t                ring_pkt [NUM_STOP];

  for (genvar i = 0; i < NUM_STOP; i++) begin : g_stop
    localparam int         PREV  = (i + NUM_STOP - 1) % NUM_STOP;
    localparam logic [7:0] MY_ID = 8'(i + 1);

    pkt_t          in_pkt;
    logic          in_vld;
    pkt_t          inj_pkt;
    logic [7:0]    inj_dst;
    logic          inj_bad;
    logic          hit;
    logic          take;
    logic          bounce;
    logic          slot_free;
    logic          full;
    logic          push;
    logic          pop;

    pkt_t          mem [INJ_DEPTH];
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] wp_q;
    logic [PW-1:0] rp_q;
    logic          slot_vld_q;
    pkt_t          slot_q;
    logic [15:0]   bcnt_q;
    logic          err_q;

    assign in_vld = ring_vld[PREV];
    assign in_pkt = ring_pkt[PREV];

    assign inj_pkt.req  = InjRequestor[i*10 +: 10];
    assign inj_pkt.op   = InjOpcode[i*OPCODE_W +: OPCODE_W];
    assign inj_pkt.addr = InjAddress[i*32 +: 32];
    assign inj_pkt.data = InjData[i*32 +: 32];

    assign inj_dst = inj_pkt.addr[31:24];
    assign inj_bad = (inj_dst == 8'd0) || (inj_dst > 8'(NUM_STOP));

    assign hit       = in_vld && (in_pkt.addr[31:24] == MY_ID);
    assign take      = hit && EjReady[i];
    assign bounce    = hit && !EjReady[i];
    // A slot is reusable when nothing arrives or the arrival leaves here.
    assign slot_free = !in_vld || take;

    assign full = (cnt_q == CW'(INJ_DEPTH));
    assign push = InjValid[i] && !full && !inj_bad;
    assign pop  = slot_free && (cnt_q != '0);

    always_ff @(posedge QClk) begin
      if (push) mem[wp_q] <= inj_pkt;
    end

    always_ff @(posedge QClk or posedge RstQnnnH) begin
      if (RstQnnnH) begin
        cnt_q      <= '0;
        wp_q       <= '0;
        rp_q       <= '0;
        slot_vld_q <= 1'b0;
        slot_q     <= '0;
        bcnt_q     <= '0;
        err_q      <= 1'b0;
      end else begin
        err_q <= InjValid[i] && inj_bad;
        if (push) wp_q <= wp_q + PW'(1);
        if (pop)  rp_q <= rp_q + PW'(1);
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
        // Ring traffic wins; local injection only fills a free slot.
        if (!slot_free) begin
          slot_vld_q <= 1'b1;
          slot_q     <= in_pkt;
        end else if (cnt_q != '0) begin
          slot_vld_q <= 1'b1;
          slot_q     <= mem[rp_q];
        end else begin
          slot_vld_q <= 1'b0;
        end
        if (bounce && bcnt_q != 16'hFFFF) bcnt_q <= bcnt_q + 16'd1;
      end
    end

    assign ring_vld[i] = slot_vld_q;
    assign ring_pkt[i] = slot_q;

    assign InjReady[i]                      = !full;
    assign InjErr[i]                        = err_q;
    assign EjValid[i]                       = hit;
    assign EjRequestor[i*10 +: 10]          = in_pkt.req;
    assign EjOpcode[i*OPCODE_W +: OPCODE_W] = in_pkt.op;
    assign EjAddress[i*32 +: 32]            = in_pkt.addr;
    assign EjData[i*32 +: 32]               = in_pkt.data;
    assign BounceCnt[i*16 +: 16]            = bcnt_q;
  end

endmodule

// File: tb/tb_lotr_ring_fabric.sv
// Directed bench for lotr_ring_fabric: latency, bounce, backpressure,
// bad-destination and reset-in-flight scenarios with hand-derived values.
module tb_lotr_ring_fabric;

  localparam int N  = 3;
  localparam int OW = 2;

  logic          QClk = 1'b0;
  logic          RstQnnnH;
  logic [N-1:0]  InjValid;
  logic [N-1:0]  InjReady;
  logic [N*10-1:0] InjRequestor;
  logic [N*OW-1:0] InjOpcode;
  logic [N*32-1:0] InjAddress;
  logic [N*32-1:0] InjData;
  logic [N-1:0]  InjErr;
  logic [N-1:0]  EjValid;
  logic [N-1:0]  EjReady;
  logic [N*10-1:0] EjRequestor;
  logic [N*OW-1:0] EjOpcode;
  logic [N*32-1:0] EjAddress;
  logic [N*32-1:0] EjData;
  logic [N*16-1:0] BounceCnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] ej2_q [$];

  lotr_ring_fabric #(.NUM_STOP(N), .INJ_DEPTH(4), .OPCODE_W(OW)) dut (
    .QClk(QClk), .RstQnnnH(RstQnnnH),
    .InjValid(InjValid), .InjReady(InjReady),
    .InjRequestor(InjRequestor), .InjOpcode(InjOpcode),
    .InjAddress(InjAddress), .InjData(InjData), .InjErr(InjErr),
    .EjValid(EjValid), .EjReady(EjReady),
    .EjRequestor(EjRequestor), .EjOpcode(EjOpcode),
    .EjAddress(EjAddress), .EjData(EjData), .BounceCnt(BounceCnt)
  );

  always #5 QClk = ~QClk;

  always @(negedge QClk)
    if (!RstQnnnH && EjValid[2] && EjReady[2]) ej2_q.push_back(EjData[95:64]);

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nclk();
    @(negedge QClk);
  endtask

  task automatic drive_inj(input int s, input logic [31:0] a,
                           input logic [31:0] d);
    InjValid[s]           = 1'b1;
    InjAddress[s*32 +: 32] = a;
    InjData[s*32 +: 32]    = d;
    InjRequestor[s*10 +: 10] = d[9:0];
    InjOpcode[s*OW +: OW]  = d[1:0];
  endtask

  initial begin
    bit done;
    RstQnnnH = 1'b1;
    InjValid = '0; InjRequestor = '0; InjOpcode = '0;
    InjAddress = '0; InjData = '0; EjReady = '1;
    #1;
    chk("rst_ejv", EjValid, 0);
    chk("rst_rdy", InjReady, 3'b111);
    chk("rst_bcnt", BounceCnt, 0);
    chk("rst_err", InjErr, 0);
    nclk(); nclk();
    RstQnnnH = 1'b0;
    nclk();

    // 1: stop0 -> stop1, one hop
    drive_inj(0, 32'h0200_0010, 32'hA5A5_A5A5);
    nclk(); InjValid = '0;
    chk("t1_e0", EjValid, 0);
    nclk();
    chk("t1_ejv", EjValid, 3'b010);
    chk("t1_addr", EjAddress[63:32], 32'h0200_0010);
    chk("t1_data", EjData[63:32], 32'hA5A5_A5A5);
    chk("t1_req", EjRequestor[19:10], 10'h1A5);
    chk("t1_op", EjOpcode[3:2], 2'b01);
    nclk();
    chk("t1_gone", EjValid, 0);

    // 2: self-addressed at stop1, full loop
    drive_inj(1, 32'h0200_0020, 32'h1111_2222);
    nclk(); InjValid = '0;
    nclk(); chk("t2_c1", EjValid, 0);
    nclk(); chk("t2_c2", EjValid, 0);
    nclk();
    chk("t2_ejv", EjValid, 3'b010);
    chk("t2_data", EjData[63:32], 32'h1111_2222);
    nclk();

    // 3: stop2 busy for two passes
    EjReady = 3'b011;
    drive_inj(0, 32'h0300_0000, 32'h0000_0033);
    nclk(); InjValid = '0;
    nclk();
    for (int c = 2; c <= 8; c++) begin
      nclk();
      chk($sformatf("t3_c%0d", c), EjValid,
          ((c - 2) % 3 == 0) ? 3'b100 : 3'b000);
      if (c == 3) chk("t3_b1", BounceCnt[47:32], 1);
      if (c == 8) EjReady = 3'b111;
    end
    nclk();
    chk("t3_gone", EjValid, 0);
    chk("t3_bcnt", BounceCnt[47:32], 2);

    // 4: starve stop0 with bouncing packets, overfill its FIFO
    EjReady = 3'b101;
    drive_inj(1, 32'h0200_0000, 32'h0000_000A);
    drive_inj(2, 32'h0200_0000, 32'h0000_000B);
    nclk(); InjValid = '0;
    drive_inj(2, 32'h0200_0000, 32'h0000_000C);
    nclk(); InjValid = '0;
    repeat (5) nclk();
    ej2_q.delete();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_rdy%0d", k), InjReady[0], 1);
      drive_inj(0, 32'h0300_0000, 32'hD0 + k);
      nclk();
    end
    chk("t4_full", InjReady[0], 0);
    drive_inj(0, 32'h0300_0000, 32'hD4);
    repeat (2) begin
      nclk();
      chk("t4_hold", InjReady[0], 0);
      chk("t4_noej", EjValid[2], 0);
    end
    chk("t4_bnc", BounceCnt[31:16] != 0, 1);
    EjReady = 3'b111;
    done = 0;
    for (int t = 0; t < 20 && !done; t++) begin
      nclk();
      if (InjReady[0]) done = 1;
    end
    chk("t4_acc", done, 1);
    nclk(); InjValid = '0;
    for (int t = 0; t < 60 && ej2_q.size() < 5; t++) nclk();
    chk("t4_cnt", ej2_q.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < ej2_q.size())
        chk($sformatf("t4_ord%0d", k), ej2_q[k], 32'hD0 + k);
    repeat (4) nclk();
    chk("t4_idle", EjValid, 0);

    // 5: bad destinations
    drive_inj(0, 32'h0000_0000, 32'h5);
    nclk(); InjValid = '0;
    chk("t5_err0", InjErr, 3'b001);
    chk("t5_rdy", InjReady, 3'b111);
    drive_inj(1, 32'h0700_0000, 32'h6);
    nclk(); InjValid = '0;
    chk("t5_err1", InjErr, 3'b010);
    nclk();
    chk("t5_clr", InjErr, 0);
    for (int c = 0; c < 4; c++) begin
      chk("t5_noej", EjValid, 0);
      nclk();
    end

    // 6: reset with packets in flight
    EjReady = 3'b110;
    drive_inj(0, 32'h0100_0000, 32'h61);
    drive_inj(1, 32'h0100_0000, 32'h62);
    drive_inj(2, 32'h0100_0000, 32'h63);
    nclk(); InjValid = '0;
    nclk(); nclk();
    RstQnnnH = 1'b1;
    #1;
    chk("t6_ejv", EjValid, 0);
    chk("t6_rdy", InjReady, 3'b111);
    chk("t6_bcnt", BounceCnt, 0);
    EjReady = 3'b111;
    nclk();
    RstQnnnH = 1'b0;
    for (int c = 0; c < 8; c++) begin
      nclk();
      chk("t6_quiet", EjValid, 0);
    end
    chk("t6_bcnt2", BounceCnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
